// File: rtl/xadc_pkg.sv
// XADC DRP address map and the scan FSM state encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package xadc_pkg;

  // DRP status/result register addresses
  localparam logic [6:0] ADDR_TEMP    = 7'h00;
  localparam logic [6:0] ADDR_VCCINT  = 7'h01;
  localparam logic [6:0] ADDR_VCCAUX  = 7'h02;
  localparam logic [6:0] ADDR_VPVN    = 7'h03;
  localparam logic [6:0] ADDR_VAUX0   = 7'h10;
  localparam logic [6:0] ADDR_VAUX1   = 7'h11;
  localparam logic [6:0] ADDR_VAUX2   = 7'h12;
  localparam logic [6:0] ADDR_VAUX3   = 7'h13;
  localparam logic [6:0] ADDR_VAUX4   = 7'h14;
  localparam logic [6:0] ADDR_VAUX5   = 7'h15;
  localparam logic [6:0] ADDR_VAUX6   = 7'h16;
  localparam logic [6:0] ADDR_VAUX7   = 7'h17;
  localparam logic [6:0] ADDR_VAUX8   = 7'h18;
  localparam logic [6:0] ADDR_VAUX9   = 7'h19;
  localparam logic [6:0] ADDR_VAUX10  = 7'h1A;
  localparam logic [6:0] ADDR_VAUX11  = 7'h1B;
  localparam logic [6:0] ADDR_VAUX12  = 7'h1C;
  localparam logic [6:0] ADDR_VAUX13  = 7'h1D;
  localparam logic [6:0] ADDR_VAUX14  = 7'h1E;
  localparam logic [6:0] ADDR_VAUX15  = 7'h1F;

  // Scan FSM encoding, shared by the top and the DRP read engine
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_ACC   = 3'd3;
  localparam logic [2:0] ST_NEXT  = 3'd4;

  // Address of auxiliary analog input n (0..15)
  function automatic logic [6:0] vauxAddr(input logic [3:0] n);
    return ADDR_VAUX0 + {3'b000, n};
  endfunction

endpackage

// File: rtl/xadc_drp_rd.sv
// Single DRP read: one-cycle enable pulse, then waits for ready or gives up after TIMEOUT cycles.
// Latency: enable 1 cycle after start; done is combinational with drpRdyIn, data valid the cycle after done.
// Backpressure: none; start is only honoured while idle, ready outside the wait window is ignored.
// Ports: clkIn/rstIn (sync, active-low); start/addr request; done/data/timeout result;
//        drpAddrOut/drpEnOut/drpDoIn/drpRdyIn to the XADC DRP port.
module xadc_drp_rd
  import xadc_pkg::*;
#(
  parameter int TIMEOUT = 63
) (
  input  logic        clkIn,
  input  logic        rstIn,
  input  logic        start,
  input  logic [6:0]  addr,
  output logic        done,
  output logic [15:0] data,
  output logic        timeout,
  output logic [6:0]  drpAddrOut,
  output logic        drpEnOut,
  input  logic [15:0] drpDoIn,
  input  logic        drpRdyIn
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [2:0]    phase;
  logic [TW-1:0] timer;

  // done/timeout are combinational so the caller leaves WAIT on the same edge that samples ready
  assign done    = (phase == ST_WAIT) && drpRdyIn;
  assign timeout = (phase == ST_WAIT) && !drpRdyIn && (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clkIn) begin
    if (!rstIn) begin
      phase      <= ST_IDLE;
      timer      <= '0;
      drpEnOut   <= 1'b0;
      drpAddrOut <= '0;
      data       <= '0;
    end else begin
      drpEnOut <= 1'b0;
      case (phase)
        ST_IDLE: begin
          if (start) begin
            drpEnOut   <= 1'b1;
            drpAddrOut <= addr;
            phase      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer <= '0;
          phase <= ST_WAIT;
        end
        ST_WAIT: begin
          if (drpRdyIn) begin
            data  <= drpDoIn;
            phase <= ST_IDLE;
          end else if (timeout) begin
            phase <= ST_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: phase <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/xadc_scan_if.sv
// Scans NUM_CH XADC result registers over DRP per end-of-conversion, averages over 2^AVG_LOG2 scans.
// Latency: eoc at t -> first drpEn at t+1, 4 cycles per channel, dataValidOut at t+4*NUM_CH (AVG_LOG2=0, 1-cycle DRP).
// Backpressure: none; one eoc is queued while busy, a further one is dropped and flagged in overrunOut.
// Ports: clkIn/rstIn (sync, active-low); eocIn; DRP master (drpAddrOut/EnOut/WeOut/DiOut, drpDoIn/RdyIn);
//        adcDataOut (channel i at [DATA_W*i +: DATA_W]) with dataValidOut pulse; busyOut, errOut, overrunOut.
module xadc_scan_if
  import xadc_pkg::*;
#(
  parameter int                  NUM_CH   = 2,
  parameter int                  DATA_W   = 12,
  parameter int                  AVG_LOG2 = 0,
  parameter logic [7*NUM_CH-1:0] CH_ADDRS = {ADDR_VAUX3, ADDR_VAUX2},
  parameter int                  TIMEOUT  = 63
) (
  input  logic                       clkIn,
  input  logic                       rstIn,
  input  logic                       eocIn,
  output logic [6:0]                 drpAddrOut,
  output logic                       drpEnOut,
  output logic                       drpWeOut,
  output logic [15:0]                drpDiOut,
  input  logic [15:0]                drpDoIn,
  input  logic                       drpRdyIn,
  output logic [NUM_CH*DATA_W-1:0]   adcDataOut,
  output logic                       dataValidOut,
  output logic                       busyOut,
  output logic                       errOut,
  output logic                       overrunOut
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW = DATA_W + AVG_LOG2;
  localparam int FW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'((1 << AVG_LOG2) - 1);

  logic [2:0]        state;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     nextIdx;
  logic [FW-1:0]     frameCnt;
  logic              pending;
  logic [AW-1:0]     acc    [NUM_CH];
  logic [AW-1:0]     sumAcc [NUM_CH];

  logic              rdStart;
  logic              rdDone;
  logic              rdTimeout;
  logic [15:0]       rdData;
  logic [6:0]        rdAddr;
  logic [DATA_W-1:0] sample;
  logic              lastCh;
  logic              frameLast;
  logic              closeWindow;
  logic              unusedRd;

  assign drpWeOut  = 1'b0;
  assign drpDiOut  = 16'h0000;
  assign busyOut   = (state != ST_IDLE);

  assign lastCh      = (idx == IW'(NUM_CH - 1));
  assign frameLast   = (frameCnt == FRAME_LAST);
  assign closeWindow = lastCh && frameLast;
  assign sample      = rdData[15 -: DATA_W];
  // low DRP bits below the result field carry nothing we use
  assign unusedRd    = ^rdData;

  // A read is launched either from IDLE (channel 0) or from NEXT (following channel)
  assign rdStart = ((state == ST_IDLE) && (eocIn || pending)) ||
                   ((state == ST_NEXT) && !lastCh);
  assign nextIdx = ((state == ST_NEXT) && !lastCh) ? IW'(idx + 1'b1) : '0;
  assign rdAddr  = CH_ADDRS[7*nextIdx +: 7];

  xadc_drp_rd #(
    .TIMEOUT(TIMEOUT)
  ) uRd (
    .clkIn      (clkIn),
    .rstIn      (rstIn),
    .start      (rdStart),
    .addr       (rdAddr),
    .done       (rdDone),
    .data       (rdData),
    .timeout    (rdTimeout),
    .drpAddrOut (drpAddrOut),
    .drpEnOut   (drpEnOut),
    .drpDoIn    (drpDoIn),
    .drpRdyIn   (drpRdyIn)
  );

  // Accumulator image with the freshly read sample folded into the current channel
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sumAcc[i] = acc[i];
      if (idx == IW'(i)) sumAcc[i] = acc[i] + AW'(sample);
    end
  end

  always_ff @(posedge clkIn) begin
    if (!rstIn) begin
      state        <= ST_IDLE;
      idx          <= '0;
      frameCnt     <= '0;
      pending      <= 1'b0;
      errOut       <= 1'b0;
      overrunOut   <= 1'b0;
      dataValidOut <= 1'b0;
      adcDataOut   <= '0;
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
    end else begin
      dataValidOut <= 1'b0;

      // One eoc may wait behind an active scan; a second one is lost
      if ((state != ST_IDLE) && eocIn) begin
        if (pending) overrunOut <= 1'b1;
        else         pending    <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (eocIn || pending) begin
            pending <= 1'b0;
            idx     <= '0;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (rdDone) begin
            state <= ST_ACC;
          end else if (rdTimeout) begin
            // partial window is unreliable: drop it, keep the last published result
            errOut   <= 1'b1;
            frameCnt <= '0;
            for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
            state    <= ST_IDLE;
          end
        end
        ST_ACC: begin
          // Closing the window on this edge makes the new result and its pulse visible during NEXT
          for (int i = 0; i < NUM_CH; i++) begin
            acc[i] <= closeWindow ? '0 : sumAcc[i];
            if (closeWindow) adcDataOut[DATA_W*i +: DATA_W] <= DATA_W'(sumAcc[i] >> AVG_LOG2);
          end
          if (lastCh) frameCnt <= frameLast ? '0 : frameCnt + 1'b1;
          if (closeWindow) dataValidOut <= 1'b1;
          state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (!lastCh) begin
            idx   <= IW'(idx + 1'b1);
            state <= ST_ISSUE;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
